// File: rtl/capture_trigger_buffer_pkg.sv
// ----------------------------------------------------------------------------
// osc_pkg: shared widths, sample type and FSM encoding for capture_trigger_buffer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package osc_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int N_SAMPLES = 256;
  localparam int DECIM_W   = 8;
  localparam int TIMEOUT_W = 20;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    WAIT_VB = 2'd3
  } cap_state_t;

endpackage : osc_pkg

`default_nettype wire

// File: rtl/capture_trigger_buffer_if.sv
// ----------------------------------------------------------------------------
// capture_trigger_buffer_if: ADC stream, trigger controls and front-buffer outputs. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface capture_trigger_buffer_if #(
  parameter int SAMPLE_W  = osc_pkg::SAMPLE_W,
  parameter int N_SAMPLES = osc_pkg::N_SAMPLES,
  parameter int DECIM_W   = osc_pkg::DECIM_W
);

  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_valid;
  logic                run;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_falling;
  logic [DECIM_W-1:0]  decim;
  logic                vblnk;
  logic [SAMPLE_W-1:0] data_display [N_SAMPLES];
  logic                frame_ready;
  logic                busy;

  modport master (
    output adc_data, adc_valid, run, trig_level, trig_falling, decim, vblnk,
    input  data_display, frame_ready, busy
  );

  modport slave (
    input  adc_data, adc_valid, run, trig_level, trig_falling, decim, vblnk,
    output data_display, frame_ready, busy
  );

endinterface : capture_trigger_buffer_if

`default_nettype wire

// File: rtl/capture_trigger_buffer_trigger_detect.sv
// ----------------------------------------------------------------------------
// trigger_detect: level/slope trigger on accepted samples; first sample after clear only primes prev. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trigger_detect #(
  parameter int SAMPLE_W = osc_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                sample_vld_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] level_i,
  input  logic                falling_i,
  output logic                trig_o
);

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                w_rise, w_fall;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    w_rise     = (prev_q < level_i) && (sample_i >= level_i);
    w_fall     = (prev_q > level_i) && (sample_i <= level_i);
    trig_o     = sample_vld_i && prev_vld_q && (falling_i ? w_fall : w_rise);
    if (clear_i) begin
      prev_vld_d = 1'b0;
    end else if (sample_vld_i) begin
      prev_d     = sample_i;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

endmodule : trigger_detect

`default_nettype wire

// File: rtl/capture_trigger_buffer.sv
// ----------------------------------------------------------------------------
// capture_trigger_buffer: decimate, trigger, capture N samples, publish on vblank edge. Rev 1.0
// Optional macro CAPTURE_AUTO_TRIG_EN forces a trigger after 2^20-1 armed samples.
// ----------------------------------------------------------------------------
`default_nettype none

module capture_trigger_buffer #(
  parameter int SAMPLE_W  = osc_pkg::SAMPLE_W,
  parameter int N_SAMPLES = osc_pkg::N_SAMPLES,
  parameter int DECIM_W   = osc_pkg::DECIM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  capture_trigger_buffer_if.slave  cap_if
);

  import osc_pkg::*;

  localparam int PTR_W = $clog2(N_SAMPLES);

  cap_state_t          state_q, state_d;
  logic [DECIM_W-1:0]  decim_q, decim_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                vblnk_q;
  logic                frame_ready_q, frame_ready_d;
  logic [SAMPLE_W-1:0] back_q  [N_SAMPLES];
  logic [SAMPLE_W-1:0] front_q [N_SAMPLES];

  logic                w_accept, w_td_vld, w_td_trig, w_force, w_trig;
  logic                w_clear, w_wr_en, w_publish, w_vb_rise;
  logic [PTR_W-1:0]    w_wr_addr;

  // Decimation: ratio latched only while idle, counter parked at 0 while idle
  always_comb begin
    decim_d  = (state_q == IDLE) ? cap_if.decim : decim_q;
    dcnt_d   = dcnt_q;
    w_accept = cap_if.adc_valid && (dcnt_q == '0);
    if (state_q == IDLE) begin
      dcnt_d = '0;
    end else if (cap_if.adc_valid) begin
      dcnt_d = (dcnt_q >= decim_q) ? '0 : dcnt_q + DECIM_W'(1);
    end
  end

  assign w_td_vld = (state_q == ARMED) && w_accept;

  trigger_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_trigger_detect (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_clear),
    .sample_vld_i (w_td_vld),
    .sample_i     (cap_if.adc_data),
    .level_i      (cap_if.trig_level),
    .falling_i    (cap_if.trig_falling),
    .trig_o       (w_td_trig)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ARMED) begin
      to_cnt_d = '0;
    end else if (w_accept) begin
      to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
    end
  end

  // The accepted sample that brings the count to 2^20-1 is the forced trigger
  assign w_force = w_td_vld && (to_cnt_q == TIMEOUT_W'((2 ** TIMEOUT_W) - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_trig    = w_td_trig || w_force;
  assign w_vb_rise = cap_if.vblnk && !vblnk_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    w_clear   = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = ptr_q;
    w_publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_if.run) begin
          state_d = ARMED;
          w_clear = 1'b1;
        end
      end
      ARMED: begin
        if (!cap_if.run) begin
          state_d = IDLE;
        end else if (w_trig) begin
          w_wr_en   = 1'b1;
          w_wr_addr = '0;
          ptr_d     = PTR_W'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          if (ptr_q == PTR_W'(N_SAMPLES - 1)) begin
            state_d = WAIT_VB;
          end
        end
      end
      WAIT_VB: begin
        if (w_vb_rise) begin
          w_publish = 1'b1;
          if (cap_if.run) begin
            state_d = ARMED;
            w_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_ready_d = w_publish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      decim_q       <= '0;
      dcnt_q        <= '0;
      ptr_q         <= '0;
      vblnk_q       <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      decim_q       <= decim_d;
      dcnt_q        <= dcnt_d;
      ptr_q         <= ptr_d;
      vblnk_q       <= cap_if.vblnk;
      frame_ready_q <= frame_ready_d;
    end
  end

  // Back buffer needs no reset: it is always fully rewritten before a publish
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      back_q[w_wr_addr] <= cap_if.adc_data;
    end
  end

  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_front
    always_ff @(posedge clk) begin
      if (rst) begin
        front_q[gi] <= '0;
      end else if (w_publish) begin
        front_q[gi] <= back_q[gi];
      end
    end
    assign cap_if.data_display[gi] = front_q[gi];
  end

  assign cap_if.frame_ready = frame_ready_q;
  assign cap_if.busy        = (state_q != IDLE);

endmodule : capture_trigger_buffer

`default_nettype wire

// File: tb/tb_capture_trigger_buffer.sv
// ----------------------------------------------------------------------------
// tb_capture_trigger_buffer: directed checks of trigger, decimation, publish gating and reset. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_capture_trigger_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  capture_trigger_buffer_if bus ();

  capture_trigger_buffer dut (
    .clk    (clk),
    .rst    (rst),
    .cap_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int v);
    bus.adc_data  = v[11:0];
    bus.adc_valid = 1'b1;
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    bus.adc_data     = '0;
    bus.adc_valid    = 1'b0;
    bus.run          = 1'b0;
    bus.trig_level   = '0;
    bus.trig_falling = 1'b0;
    bus.decim        = '0;
    bus.vblnk        = 1'b0;
    step(3);
    check("rst_frame_ready", 32'(bus.frame_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_disp0", 32'(bus.data_display[0]), 0);
    check("rst_disp255", 32'(bus.data_display[255]), 0);
    rst = 1'b0;

    // Rising ramp, level 2048
    bus.trig_level = 12'd2048;
    bus.run        = 1'b1;
    step(1);
    check("t1_armed_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 384; k++) push((k * 16) & 32'hFFF);
    check("t1_wait_busy", 32'(bus.busy), 1);
    check("t1_no_publish_fr", 32'(bus.frame_ready), 0);
    check("t1_hold_disp0", 32'(bus.data_display[0]), 0);
    bus.run = 1'b0;
    step(2);
    bus.vblnk = 1'b1;
    step(1);
    check("t1_fr_pulse", 32'(bus.frame_ready), 1);
    check("t1_disp0", 32'(bus.data_display[0]), 2048);
    check("t1_disp1", 32'(bus.data_display[1]), 2064);
    check("t1_disp127", 32'(bus.data_display[127]), 4080);
    check("t1_disp128", 32'(bus.data_display[128]), 0);
    check("t1_disp255", 32'(bus.data_display[255]), 2032);
    step(1);
    check("t1_fr_low", 32'(bus.frame_ready), 0);
    check("t1_idle_busy", 32'(bus.busy), 0);
    bus.vblnk = 1'b0;

    // Falling ramp, level 1000
    bus.trig_falling = 1'b1;
    bus.trig_level   = 12'd1000;
    bus.run          = 1'b1;
    step(1);
    for (int k = 0; k < 450; k++) push((4095 - 16 * k) & 32'hFFF);
    bus.run   = 1'b0;
    bus.vblnk = 1'b1;
    step(1);
    check("t2_fr_pulse", 32'(bus.frame_ready), 1);
    check("t2_disp0", 32'(bus.data_display[0]), 991);
    check("t2_disp1", 32'(bus.data_display[1]), 975);
    check("t2_disp61", 32'(bus.data_display[61]), 15);
    check("t2_disp62", 32'(bus.data_display[62]), 4095);
    check("t2_disp255", 32'(bus.data_display[255]), 1007);
    step(1);
    check("t2_fr_low", 32'(bus.frame_ready), 0);
    bus.vblnk = 1'b0;

    // decim=3 on a counting sequence; a mid-capture change to decim is ignored
    bus.trig_falling = 1'b0;
    bus.trig_level   = 12'd100;
    bus.decim        = 8'd3;
    bus.run          = 1'b1;
    step(1);
    for (int v = 0; v < 1124; v++) begin
      if (v == 500) bus.decim = '0;
      push(v);
    end
    check("t3_wait_busy", 32'(bus.busy), 1);
    bus.run   = 1'b0;
    bus.vblnk = 1'b1;
    step(1);
    check("t3_fr_pulse", 32'(bus.frame_ready), 1);
    check("t3_disp0", 32'(bus.data_display[0]), 100);
    check("t3_disp1", 32'(bus.data_display[1]), 104);
    check("t3_disp128", 32'(bus.data_display[128]), 612);
    check("t3_diff", 32'(bus.data_display[200]) - 32'(bus.data_display[199]), 4);
    check("t3_disp255", 32'(bus.data_display[255]), 1120);
    step(1);
    bus.vblnk = 1'b0;
    bus.decim = '0;

    // Capture finishes with vblnk already high: publish waits for a fresh rising edge
    bus.vblnk      = 1'b1;
    bus.trig_level = 12'd2048;
    bus.run        = 1'b1;
    step(1);
    for (int k = 0; k < 384; k++) push((k * 16) & 32'hFFF);
    step(3);
    check("t4_hold_fr", 32'(bus.frame_ready), 0);
    check("t4_hold_disp0", 32'(bus.data_display[0]), 100);
    bus.vblnk = 1'b0;
    step(1);
    check("t4_low_fr", 32'(bus.frame_ready), 0);
    check("t4_low_disp0", 32'(bus.data_display[0]), 100);
    bus.vblnk = 1'b1;
    step(1);
    check("t4_fr_pulse", 32'(bus.frame_ready), 1);
    check("t4_disp0", 32'(bus.data_display[0]), 2048);
    check("t4_rearm_busy", 32'(bus.busy), 1);
    bus.run = 1'b0;
    step(1);
    check("t4_stop_fr", 32'(bus.frame_ready), 0);
    check("t4_stop_busy", 32'(bus.busy), 0);
    bus.vblnk = 1'b0;

    // Reset at ptr=100, then re-arm: first accepted sample must not trigger
    bus.run = 1'b1;
    step(1);
    for (int k = 0; k < 228; k++) push((k * 16) & 32'hFFF);
    rst = 1'b1;
    step(1);
    check("t5_rst_fr", 32'(bus.frame_ready), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_disp0", 32'(bus.data_display[0]), 0);
    check("t5_rst_disp255", 32'(bus.data_display[255]), 0);
    rst = 1'b0;
    step(1);
    check("t5_rearm_busy", 32'(bus.busy), 1);
    push(3000);
    bus.run = 1'b0;
    step(1);
    check("t5_no_trig_busy", 32'(bus.busy), 0);

    // run drops mid-capture: capture and publish still complete, exactly once
    bus.run = 1'b1;
    step(1);
    for (int k = 0; k < 384; k++) begin
      if (k == 200) bus.run = 1'b0;
      push((k * 16) & 32'hFFF);
    end
    check("t6_wait_busy", 32'(bus.busy), 1);
    bus.vblnk = 1'b1;
    pulses = 0;
    repeat (6) begin
      step(1);
      pulses += int'(bus.frame_ready);
    end
    check("t6_pulses", 32'(pulses), 1);
    check("t6_idle_busy", 32'(bus.busy), 0);
    check("t6_disp255", 32'(bus.data_display[255]), 2032);
    bus.vblnk = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_capture_trigger_buffer

`default_nettype wire

// File: doc/capture_trigger_buffer.md
Name: capture_trigger_buffer

Overview:
- Upstream stage of the display renderer. Accepts a decimated 12-bit ADC sample stream and waits for a level/slope trigger.
- After the trigger, captures 256 consecutive samples into a back buffer.
- Publishes the back buffer atomically into the 256x12 front array during vertical blanking, so the renderer never reads a half-updated trace.
- Sits between the ADC interface and the display drawing stage; drives its data_display input.

Parameters:
- SAMPLE_W, 12, sample width in bits.
- N_SAMPLES, 256, samples per captured trace; must be a power of two.
- DECIM_W, 8, width of the decimation ratio input.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- adc_data  in  SAMPLE_W  raw sample
- adc_valid  in  1  adc_data valid this cycle
- run  in  1  1 = continuously re-arm; 0 = stop after the current capture is published
- trig_level  in  SAMPLE_W  trigger threshold, unsigned
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
- decim  in  DECIM_W  keep 1 of every decim+1 valid samples
- vblnk  in  1  vertical blanking from the timing chain
- data_display  out  SAMPLE_W x [0:N_SAMPLES-1]  front buffer, registered
- frame_ready  out  1  one-cycle pulse on publish
- busy  out  1  high in ARMED, CAPTURE and WAIT_VB

Behaviour:
- Reset state:
  - All outputs 0: every data_display word 0, frame_ready 0, busy 0.
  - FSM in IDLE; decimation counter, write pointer and the prev-valid flag all 0.
  - Reset mid-capture discards the back buffer; data_display is cleared.
- Decimation:
  - Counter increments on each adc_valid and wraps at decim. A sample is accepted when the counter equals 0.
  - decim = 0 accepts every valid sample.
  - decim is sampled only in IDLE. Changes during a capture take effect on the next arm.
- FSM states:
  - IDLE: if run=1, go to ARMED next cycle and clear the prev-valid flag.
  - ARMED:
    - The first accepted sample only loads prev and sets prev-valid.
    - On later accepted samples, a rising trigger fires when prev < trig_level and curr >= trig_level.
    - A falling trigger fires when prev > trig_level and curr <= trig_level.
    - On trigger, the triggering sample is written to back[0]; pointer := 1; go to CAPTURE.
  - CAPTURE: each accepted sample is written to back[ptr] and ptr increments. When the sample is written at ptr = N_SAMPLES-1, go to WAIT_VB. No wrap-around writes.
  - WAIT_VB:
    - On the first cycle where vblnk=1 and the previous vblnk was 0 (rising edge), copy all of back to data_display in one cycle and pulse frame_ready the same cycle.
    - Next state is ARMED if run=1, else IDLE.
    - If vblnk is already high on entry, wait for the next rising edge.
- run=0 in ARMED returns to IDLE next cycle. run=0 in CAPTURE or WAIT_VB finishes the capture and publish, then goes to IDLE.
- Samples arriving in WAIT_VB are dropped. adc_valid=0 cycles do not advance any counter.
- Comparisons are unsigned, full SAMPLE_W. A sample equal to the level with prev equal to the level does not trigger.
- Latency: data_display and frame_ready update on the clock edge after vblnk rises. data_display is stable at all other times.

Optional Feature:
- Macro CAPTURE_AUTO_TRIG_EN.
- When defined:
  - A 20-bit timeout counter runs in ARMED, counting accepted samples.
  - When it reaches 2^20-1 without a trigger, force a trigger on the current sample, so flat signals still display.
  - The counter clears on entering ARMED.
- When undefined: no counter; ARMED waits indefinitely.

Decomposition:
- Package osc_pkg holds:
  - SAMPLE_W and N_SAMPLES constants
  - typedef logic [SAMPLE_W-1:0] sample_t
  - enum cap_state_t {IDLE, ARMED, CAPTURE, WAIT_VB}
- One sub-module, trigger_detect: holds the prev register and prev-valid flag, compares against level/slope, and outputs a one-cycle trig pulse aligned to the accepted sample.

Test Plan:
- Ramp 0..4095 step 16, decim=0, level=2048, rising: first trigger sample 2048 lands at back[0]; after vblnk rises, data_display[0]=2048, data_display[255]=6128 mod 4096; frame_ready pulses once.
- Same ramp descending with trig_falling=1, level=1000: data_display[0] is the first sample <= 1000 following a sample > 1000.
- decim=3 with a counting sequence 0,1,2,...: data_display holds every 4th value; consecutive word difference is 4.
- Publish gating: capture completes while vblnk=1, then vblnk low then high again: no publish until the second rising edge; data_display unchanged before it.
- Reset asserted mid-CAPTURE (ptr=100): next cycle all outputs 0 and state IDLE; with run=1, re-arm; the first accepted sample does not trigger.
- run=0 during CAPTURE: exactly one frame_ready, then IDLE with busy=0; with CAPTURE_AUTO_TRIG_EN and a constant input of 500, a forced trigger occurs after 2^20-1 accepted samples.
